// File: rtl/nw_fill_ctrl.sv
// Needleman-Wunsch score-matrix fill sequencer.
// Starts both sequence converters, waits for their joint done, then walks every
// (LEN+1)x(LEN+1) cell row-major over a valid/ready handshake to the cell PE.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for start
// LOAD   | converters running; first cycle pulses load_start, ignores load_done
// FILL   | presenting cells (row,col) to the PE, advancing on each handshake
// FINISH | single-cycle done pulse, indices parked at (LEN,LEN)
module nw_fill_ctrl #(
   parameter int LEN   = 8,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             load_start,
   input  logic             load_done,
   output logic             cell_valid,
   input  logic             cell_ready,
   output logic             cell_init,
   output logic [IDX_W-1:0] row,
   output logic [IDX_W-1:0] col,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_FILL   = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN);

   state_t           state, state_nxt;
   logic [IDX_W-1:0] row_nxt, col_nxt;
   logic             load_start_nxt;
   logic             cell_valid_nxt;
   logic             cell_init_nxt;
   logic             busy_nxt;
   logic             done_nxt;
   logic             handshake;

   // cell_valid is registered and high for the whole of FILL, so it gates the handshake
   assign handshake = cell_valid && cell_ready;

   // State and registered outputs; active-low reset returns everything to IDLE/zero
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= S_IDLE;
         row        <= '0;
         col        <= '0;
         load_start <= 1'b0;
         cell_valid <= 1'b0;
         cell_init  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nxt;
         row        <= row_nxt;
         col        <= col_nxt;
         load_start <= load_start_nxt;
         cell_valid <= cell_valid_nxt;
         cell_init  <= cell_init_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
      end
   end

   // Next-state and next-output values for the registered outputs
   always_comb begin
      state_nxt      = state;
      row_nxt        = row;
      col_nxt        = col;
      load_start_nxt = 1'b0;
      cell_valid_nxt = 1'b0;
      cell_init_nxt  = 1'b0;
      busy_nxt       = 1'b0;
      done_nxt       = 1'b0;

      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt      = S_LOAD;
               load_start_nxt = 1'b1;
               busy_nxt       = 1'b1;
            end
         end

         S_LOAD: begin
            busy_nxt = 1'b1;
            // load_start high means this is the first LOAD cycle, where load_done
            // may still be left over from the previous run
            if (!load_start && load_done) begin
               state_nxt      = S_FILL;
               row_nxt        = '0;
               col_nxt        = '0;
               cell_valid_nxt = 1'b1;
               cell_init_nxt  = 1'b1;
            end
         end

         S_FILL: begin
            busy_nxt       = 1'b1;
            cell_valid_nxt = 1'b1;
            cell_init_nxt  = cell_init;
            if (handshake) begin
               if (col == LAST_IDX) begin
                  if (row == LAST_IDX) begin
                     state_nxt      = S_FINISH;
                     cell_valid_nxt = 1'b0;
                     cell_init_nxt  = 1'b0;
                     busy_nxt       = 1'b0;
                     done_nxt       = 1'b1;
                  end else begin
                     row_nxt       = row + 1'b1;
                     col_nxt       = '0;
                     cell_init_nxt = 1'b1;
                  end
               end else begin
                  col_nxt       = col + 1'b1;
                  cell_init_nxt = (row == '0);
               end
            end
         end

         S_FINISH: begin
            state_nxt = S_IDLE;
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_nw_fill_ctrl.sv
// Bench for nw_fill_ctrl: randomized runs on a LEN=8 instance checked against a
// row-major cell list, plus a short directed run on a LEN=1 instance.
module tb_nw_fill_ctrl;

   localparam int LEN   = 8;
   localparam int IDX_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             start, load_done, cell_ready;
   logic             load_start, cell_valid, cell_init, busy, done;
   logic [IDX_W-1:0] row, col;

   logic             start1, load_done1, cell_ready1;
   logic             load_start1, cell_valid1, cell_init1, busy1, done1;
   logic [0:0]       row1, col1;

   int n_vec = 0;
   int n_err = 0;

   int got_r[$];
   int got_c[$];
   int got_i[$];

   always #5 clk = ~clk;

   nw_fill_ctrl #(.LEN(LEN), .IDX_W(IDX_W)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .load_start (load_start),
      .load_done  (load_done),
      .cell_valid (cell_valid),
      .cell_ready (cell_ready),
      .cell_init  (cell_init),
      .row        (row),
      .col        (col),
      .busy       (busy),
      .done       (done)
   );

   nw_fill_ctrl #(.LEN(1), .IDX_W(1)) u_dut1 (
      .clk        (clk),
      .rst        (rst),
      .start      (start1),
      .load_start (load_start1),
      .load_done  (load_done1),
      .cell_valid (cell_valid1),
      .cell_ready (cell_ready1),
      .cell_init  (cell_init1),
      .row        (row1),
      .col        (col1),
      .busy       (busy1),
      .done       (done1)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_load_start"}, int'(load_start), 0);
      chk({tag, "_valid"},      int'(cell_valid), 0);
      chk({tag, "_busy"},       int'(busy),       0);
      chk({tag, "_done"},       int'(done),       0);
   endtask

   // One fill run. bp_pct: chance of ready=0 per FILL cycle; spur: random start
   // while not idle; bp25: hold ready low 3 cycles at (2,5); abort34: reset at
   // (3,4); ld_early: load_done already high before start.
   task automatic run_fill(input int bp_pct, input bit spur, input bit bp25,
                           input bit abort34, input bit ld_early);
      int q_r[$];
      int q_c[$];
      int d;
      int budget;
      int bp_left;
      bit hs;
      for (int r = 0; r <= LEN; r++)
         for (int c = 0; c <= LEN; c++) begin
            q_r.push_back(r);
            q_c.push_back(c);
         end

      load_done  = ld_early;
      cell_ready = 1'($urandom % 2);
      start      = 1'b1;
      tick();
      chk("ls_pulse",   int'(load_start), 1);
      chk("busy_load",  int'(busy),       1);
      chk("valid_load", int'(cell_valid), 0);

      start     = spur ? 1'($urandom % 2) : 1'b0;
      load_done = ld_early ? 1'b1 : 1'($urandom % 2);
      tick();
      chk("ls_once",     int'(load_start), 0);
      chk("valid_load2", int'(cell_valid), 0);
      chk("busy_load2",  int'(busy),       1);

      d = $urandom_range(0, 5);
      for (int i = 0; i < d; i++) begin
         load_done  = 1'b0;
         start      = spur ? 1'($urandom % 2) : 1'b0;
         cell_ready = 1'($urandom % 2);
         tick();
         chk("wait_valid", int'(cell_valid), 0);
         chk("wait_ls",    int'(load_start), 0);
         chk("wait_busy",  int'(busy),       1);
      end
      load_done = 1'b1;
      start     = spur ? 1'($urandom % 2) : 1'b0;
      tick();

      budget  = 0;
      bp_left = 3;
      while (q_r.size() > 0 && budget < 4000) begin
         budget++;
         chk("valid", int'(cell_valid), 1);
         chk("row",   int'(row),        q_r[0]);
         chk("col",   int'(col),        q_c[0]);
         chk("init",  int'(cell_init),  int'(q_r[0] == 0 || q_c[0] == 0));
         chk("busy",  int'(busy),       1);
         chk("done_early", int'(done),  0);
         chk("ls_fill", int'(load_start), 0);

         if (abort34 && q_r[0] == 3 && q_c[0] == 4) begin
            rst       = 1'b0;
            start     = 1'b0;
            load_done = 1'b0;
            tick();
            chk_quiet("rst1");
            chk("rst1_init", int'(cell_init), 0);
            chk("rst1_row",  int'(row),       0);
            chk("rst1_col",  int'(col),       0);
            tick();
            chk_quiet("rst2");
            rst = 1'b1;
            tick();
            chk_quiet("rst_idle");
            return;
         end

         if (bp25 && q_r[0] == 2 && q_c[0] == 5 && bp_left > 0) begin
            cell_ready = 1'b0;
            bp_left--;
         end else begin
            cell_ready = ($urandom_range(0, 99) >= bp_pct);
         end
         load_done = 1'($urandom % 2);
         start     = spur ? 1'($urandom % 2) : 1'b0;
         hs        = cell_ready;
         tick();
         if (hs) begin
            void'(q_r.pop_front());
            void'(q_c.pop_front());
         end
      end
      chk("fill_budget", q_r.size(), 0);

      chk("fin_done",  int'(done),       1);
      chk("fin_busy",  int'(busy),       0);
      chk("fin_valid", int'(cell_valid), 0);
      chk("fin_row",   int'(row),        LEN);
      chk("fin_col",   int'(col),        LEN);
      chk("fin_ls",    int'(load_start), 0);
      start      = spur;
      cell_ready = 1'($urandom % 2);
      load_done  = 1'b0;
      tick();
      chk_quiet("post_fin");
      start = 1'b0;
      tick();
      chk_quiet("post_idle");
   endtask

   initial begin : main
      int exp_r[4];
      int exp_c[4];
      int exp_i[4];
      int done_seen;
      exp_r = '{0, 0, 1, 1};
      exp_c = '{0, 1, 0, 1};
      exp_i = '{1, 1, 1, 0};

      rst         = 1'b0;
      start       = 1'b0;
      load_done   = 1'b0;
      cell_ready  = 1'b0;
      start1      = 1'b0;
      load_done1  = 1'b0;
      cell_ready1 = 1'b1;
      tick();
      tick();
      chk_quiet("reset");
      chk("reset_row",  int'(row),       0);
      chk("reset_col",  int'(col),       0);
      chk("reset_init", int'(cell_init), 0);
      chk("reset1_busy", int'(busy1),    0);
      rst = 1'b1;
      tick();
      chk_quiet("idle");

      run_fill(0,  1'b0, 1'b0, 1'b0, 1'b0);
      run_fill(30, 1'b1, 1'b1, 1'b0, 1'b0);
      run_fill(0,  1'b0, 1'b0, 1'b1, 1'b0);
      run_fill(0,  1'b0, 1'b0, 1'b0, 1'b0);
      run_fill(0,  1'b1, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++)
         run_fill($urandom_range(0, 60), 1'b1, 1'b0, 1'b0, 1'($urandom % 2));

      // LEN=1 instance: ready held high, load_done already high before start
      start1     = 1'b1;
      load_done1 = 1'b1;
      tick();
      chk("len1_ls", int'(load_start1), 1);
      start1    = 1'b0;
      done_seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (cell_valid1) begin
            got_r.push_back(int'(row1));
            got_c.push_back(int'(col1));
            got_i.push_back(int'(cell_init1));
         end
         if (done1) begin
            done_seen++;
            chk("len1_fin_row", int'(row1), 1);
            chk("len1_fin_col", int'(col1), 1);
            break;
         end
      end
      chk("len1_done",  done_seen,     1);
      chk("len1_count", got_r.size(),  4);
      for (int i = 0; i < 4; i++) begin
         if (i < got_r.size()) begin
            chk("len1_row",  got_r[i], exp_r[i]);
            chk("len1_col",  got_c[i], exp_c[i]);
            chk("len1_init", got_i[i], exp_i[i]);
         end
      end
      tick();
      chk("len1_done_clr", int'(done1), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
